// File: rtl/alu_pkg.sv
// alu_pkg: opcode and flag types shared by the pipelined ALU and its compute core
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_AND, OP_OR, OP_XOR, OP_NOT,
        OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR, OP_CMP, OP_PASS, OP_RSVD
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
        logic negative;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU with carry-in, producing result and flags
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          op_i,
    input  logic             cf_i,
    output logic [WIDTH-1:0] r_o,
    output alu_flags_t       flags_o
);

    localparam int M = WIDTH - 1;

    logic [SHW-1:0] n, nn;
    logic           cin, c, v;
    logic [WIDTH:0] sum, dif, shl, shr, asr;

    assign n   = b_i[SHW-1:0];
    assign nn  = -n;
    assign cin = (op_i == OP_ADC || op_i == OP_SBB) && cf_i;
    assign sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin};
    // the extra top bit of the difference is the borrow
    assign dif = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin};
    assign shl = {1'b0, a_i} << n;
    assign shr = {a_i, 1'b0} >> n;
    assign asr = $signed({a_i, 1'b0}) >>> n;

    always_comb begin
        r_o = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op_i)
            OP_ADD, OP_ADC: begin
                r_o = sum[M:0];
                c   = sum[WIDTH];
                v   = ~(a_i[M] ^ b_i[M]) & (a_i[M] ^ sum[M]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                r_o = (op_i == OP_CMP) ? a_i : dif[M:0];
                c   = dif[WIDTH];
                v   = (a_i[M] ^ b_i[M]) & (a_i[M] ^ dif[M]);
            end
            OP_AND:  r_o = a_i & b_i;
            OP_OR:   r_o = a_i | b_i;
            OP_XOR:  r_o = a_i ^ b_i;
            OP_NOT:  r_o = ~a_i;
            OP_SHL:  {c, r_o} = shl;
            OP_SHR:  {r_o, c} = shr;
            OP_ASR:  {r_o, c} = asr;
            // rotate by n == shift by n OR'd with shift back by (-n mod WIDTH)
            OP_ROL: begin
                r_o = (a_i << n) | (a_i >> nn);
                c   = r_o[0];
            end
            OP_ROR: begin
                r_o = (a_i >> n) | (a_i << nn);
                c   = r_o[M];
            end
            OP_PASS: r_o = b_i;
            default: ;
        endcase
        flags_o.carry    = c;
        flags_o.zero     = (r_o == '0);
        flags_o.overflow = v;
        flags_o.negative = r_o[M];
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU with an architectural carry flag
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Zero,
    output logic             Overflow,
    output logic             Negative
);

    logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d, cf_q, cf_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, core_r;
    alu_op_e          op_q, op_d;
    alu_flags_t       flags_q, flags_d, core_flags;
    logic             s2_adv, mv, ld;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign mv       = s2_adv && s1_valid_q;
    assign ld       = in_ready && in_valid;

    alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
        .a_i     (a_q),
        .b_i     (b_q),
        .op_i    (op_q),
        .cf_i    (cf_q),
        .r_o     (core_r),
        .flags_o (core_flags)
    );

    always_comb begin
        s1_valid_d  = in_ready ? in_valid : s1_valid_q;
        a_d         = ld ? A : a_q;
        b_d         = ld ? B : b_q;
        op_d        = ld ? alu_op_e'(Opcode) : op_q;
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        res_d       = mv ? core_r : res_q;
        flags_d     = mv ? core_flags : flags_q;
        // cf follows program order: it changes only when an op enters S2
        cf_d        = mv ? core_flags.carry : cf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            cf_q        <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            cf_q        <= cf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Result    = res_q;
    assign Carry     = flags_q.carry;
    assign Zero      = flags_q.zero;
    assign Overflow  = flags_q.overflow;
    assign Negative  = flags_q.negative;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe (WIDTH=8) against an integer reference model
module tb_alu_pipe;

    logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] A, B, Result;
    logic [3:0] Opcode;
    logic       Carry, Zero, Overflow, Negative;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Opcode(Opcode), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Carry(Carry), .Zero(Zero), .Overflow(Overflow), .Negative(Negative)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] exp;
        int          t;
    } ent_t;

    ent_t        q[$];
    logic [11:0] outs[$];
    int          n_vec = 0, n_err = 0, n_acc = 0, cyc = 0, mcf = 0;
    logic        in_fire, out_fire;
    logic [11:0] obs;

    // {Result, Carry, Zero, Overflow, Negative} from plain integer arithmetic
    function automatic logic [11:0] model(input int op, input int a, input int b, input int cf);
        int r, c, v, sa, sb, s, n;
        sa = a > 127 ? a - 256 : a;
        sb = b > 127 ? b - 256 : b;
        n = b % 8;
        r = 0; c = 0; v = 0;
        case (op)
            0, 2: begin
                s = a + b + (op == 2 ? cf : 0);
                r = s % 256; c = int'(s > 255);
                s = sa + sb + (op == 2 ? cf : 0);
                v = int'(s > 127 || s < -128);
            end
            1, 3, 13: begin
                s = a - b - (op == 3 ? cf : 0);
                r = op == 13 ? a : (s + 256) % 256; c = int'(s < 0);
                s = sa - sb - (op == 3 ? cf : 0);
                v = int'(s > 127 || s < -128);
            end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = 255 - a;
            8: begin r = (a << n) % 256; c = n > 0 ? (a >> (8 - n)) & 1 : 0; end
            9: begin r = a >> n; c = n > 0 ? (a >> (n - 1)) & 1 : 0; end
            10: begin r = (sa >>> n) & 255; c = n > 0 ? (sa >>> (n - 1)) & 1 : 0; end
            11: begin r = a; repeat (n) r = ((r << 1) | (r >> 7)) & 255; c = r & 1; end
            12: begin r = a; repeat (n) r = (r >> 1) | ((r & 1) << 7); c = r >> 7; end
            14: r = b;
            default: r = 0;
        endcase
        return {r[7:0], c[0], r == 0, v[0], r > 127};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] got(input int i);
        return i < outs.size() ? outs[i] : 12'hxxx;
    endfunction

    // one clock: check at negedge, then update the scoreboard on the edge
    task automatic tick();
        logic exp_ov;
        ent_t e;
        @(negedge clk);
        exp_ov = q.size() == 2 || (q.size() == 1 && cyc - q[0].t >= 1);
        chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
        chk("out_valid", out_valid, exp_ov);
        obs = {Result, Carry, Zero, Overflow, Negative};
        if (out_valid && q.size() > 0) chk("result", obs, q[0].exp);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            q.delete();
            mcf = 0;
        end else begin
            if (out_fire && q.size() > 0) begin
                void'(q.pop_front());
                outs.push_back(obs);
            end
            if (in_fire) begin
                e.exp = model(int'(Opcode), int'(A), int'(B), mcf);
                e.t = cyc;
                mcf = int'(e.exp[3]);
                q.push_back(e);
                n_acc++;
            end
        end
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int k = 0;
        in_valid = 1; Opcode = op; A = a; B = b;
        do begin tick(); k++; end while (!in_fire && k < 20);
        chk("push_accept", in_fire, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int start;
        clk = 0; rst_n = 0; in_valid = 0; A = 0; B = 0; Opcode = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {Result, Carry, Zero, Overflow, Negative}, 12'h000);
        chk("rst_in_ready", in_ready, 1);

        outs.delete();
        push(4'd0, 8'h7F, 8'h01);
        drain();
        chk("add_ovf", got(0), 12'h803);

        outs.delete();
        push(4'd1, 8'h00, 8'h01);
        push(4'd3, 8'h00, 8'h00);
        drain();
        chk("sub_borrow", got(0), 12'hFF9);
        chk("sbb_cf", got(1), 12'hFF9);

        outs.delete();
        push(4'd0, 8'hFF, 8'h01);
        push(4'd2, 8'h00, 8'h00);
        drain();
        chk("add_carry", got(0), 12'h00C);
        chk("adc_cf", got(1), 12'h010);

        outs.delete();
        out_ready = 0;
        push(4'd0, 8'hFF, 8'h01);
        push(4'd2, 8'h00, 8'h00);
        in_valid = 1; Opcode = 4'd14; A = 8'h00; B = 8'h55;
        repeat (3) begin
            tick();
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid = 0;
        drain();
        chk("stall_count", outs.size(), 2);
        chk("stall_add", got(0), 12'h00C);
        chk("stall_adc", got(1), 12'h010);

        outs.delete();
        push(4'd8, 8'h81, 8'h01);
        push(4'd10, 8'h80, 8'h03);
        push(4'd12, 8'h01, 8'h01);
        push(4'd9, 8'hA5, 8'h00);
        drain();
        chk("shl", got(0), 12'h028);
        chk("asr", got(1), 12'hF01);
        chk("ror", got(2), 12'h809);
        chk("shr0", got(3), 12'hA51);

        start = n_acc;
        for (int i = 0; i < 40000 && n_acc < start + 10000; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            A = 8'($urandom); B = 8'($urandom); Opcode = 4'($urandom);
            tick();
        end
        chk("random_ops", n_acc >= start + 10000, 1);
        drain();

        outs.delete();
        out_ready = 0;
        push(4'd0, 8'hFF, 8'h01);
        push(4'd0, 8'h01, 8'h02);
        tick();
        chk("full_before_rst", out_valid, 1);
        rst_n = 0;
        in_valid = 1; Opcode = 4'd0; A = 8'h11; B = 8'h22;
        tick();
        rst_n = 1; in_valid = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_flags", {Result, Carry, Zero, Overflow, Negative}, 12'h000);
        push(4'd2, 8'h01, 8'h01);
        drain();
        chk("midrst_count", outs.size(), 1);
        chk("midrst_adc", got(0), 12'h020);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
